imm_decode_stage: RTL and testbench



---
 rtl/imm_pkg.sv | 43 ++++
 rtl/imm_sel_decode.sv | 33 +++
 rtl/imm_decode_stage.sv | 134 +++++++++++++
 tb/tb_imm_decode_stage.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-format decode path: format codes,
// base opcodes, the decoded-entry record and the skid-buffer state type.
package imm_pkg;

    // Instruction/PC width carried by a decoded entry; the stage's XLEN
    // parameter must match this value.
    localparam int IMM_XLEN = 32;

    typedef logic [2:0] imm_src_t;

    localparam imm_src_t IMM_I = 3'b000;
    localparam imm_src_t IMM_S = 3'b001;
    localparam imm_src_t IMM_B = 3'b010;
    localparam imm_src_t IMM_J = 3'b011;
    localparam imm_src_t IMM_U = 3'b100;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // One decoded instruction as it travels through the stage.
    typedef struct packed {
        logic [IMM_XLEN-1:0] instr;
        logic [IMM_XLEN-1:0] pc;
        imm_src_t            imm_src;
        logic                uses_imm;
        logic                illegal;
    } entry_t;

    // Encoded as {skid_valid, main_valid} so the valid bits are the state.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } skid_state_t;

endpackage

// File: rtl/imm_sel_decode.sv
// Combinational opcode classifier: selects the immediate format and flags
// whether the instruction uses an immediate or is outside the supported set.
module imm_sel_decode
    import imm_pkg::*;
(
    input  logic [6:0] opcode,
    output imm_src_t   imm_src,
    output logic       uses_imm,
    output logic       illegal
);

    // Map the base opcode onto its immediate format.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // through the block leaves a value unassigned (which would infer a latch).
        imm_src  = IMM_I;
        uses_imm = 1'b1;
        illegal  = 1'b0;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR: imm_src = IMM_I;
            OP_STORE:                 imm_src = IMM_S;
            OP_BRANCH:                imm_src = IMM_B;
            OP_JAL:                   imm_src = IMM_J;
            OP_LUI, OP_AUIPC:         imm_src = IMM_U;
            OP_REG:                   uses_imm = 1'b0;
            default: begin
                uses_imm = 1'b0;
                illegal  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered decode stage: classifies incoming instructions, stores the
// decoded entry in a two-entry skid buffer (main + skid) so both handshakes
// are registered, supports flush and counts back-pressure cycles.
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN        = IMM_XLEN,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        in_instr,
    input  logic [XLEN-1:0]        in_pc,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_instr,
    output logic [XLEN-1:0]        out_pc,
    output logic [2:0]             out_imm_src,
    output logic                   out_uses_imm,
    output logic                   out_illegal,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    skid_state_t            state_q, state_d;
    entry_t                 main_q, skid_q, in_entry;
    imm_src_t               dec_imm_src;
    logic                   dec_uses_imm, dec_illegal;
    logic                   accept, drain;
    logic                   load_main_in, load_main_skid, load_skid;
    logic [STALL_CNT_W-1:0] stall_q;

    imm_sel_decode u_sel (
        .opcode   (in_instr[6:0]),
        .imm_src  (dec_imm_src),
        .uses_imm (dec_uses_imm),
        .illegal  (dec_illegal)
    );

    // Decode happens on the input side; the result is stored with the entry.
    always_comb begin
        in_entry.instr    = in_instr;
        in_entry.pc       = in_pc;
        in_entry.imm_src  = dec_imm_src;
        in_entry.uses_imm = dec_uses_imm;
        in_entry.illegal  = dec_illegal;
    end

    // Both ready and valid are taken straight from state bits.
    assign in_ready  = ~state_q[1];
    assign out_valid = state_q[0];
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    // Next state and register-load selects; flush overrides every event.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d      = ST_ONE;
                    load_main_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    state_d   = ST_FULL;
                    load_skid = 1'b1;
                end else if (drain) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (drain) begin
                    state_d        = ST_ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d        = ST_EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    // Skid-buffer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) state_q <= ST_EMPTY;
        else        state_q <= state_d;
    end

    // Entry registers: main feeds the outputs, skid absorbs one extra entry.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: data registers are reset too, so outputs start at defined
        // values and out_imm_src never carries X while the stage is empty.
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in)        main_q <= in_entry;
            else if (load_main_skid) main_q <= skid_q;
            if (load_skid)           skid_q <= in_entry;
        end
    end

    // Saturating count of cycles the output is held by back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && stall_q != '1) begin
            stall_q <= stall_q + STALL_CNT_W'(1);
        end
    end

    assign out_instr    = main_q.instr;
    assign out_pc       = main_q.pc;
    assign out_imm_src  = main_q.imm_src;
    assign out_uses_imm = main_q.uses_imm;
    assign out_illegal  = main_q.illegal;
    assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench for imm_decode_stage: directed scenarios followed by
// randomized traffic, compared each cycle against a two-deep FIFO model.
module tb_imm_decode_stage;

    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0]   in_instr, in_pc, out_instr, out_pc;
    logic [2:0]    out_imm_src;
    logic          out_uses_imm, out_illegal;
    logic [SW-1:0] stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  src;
        logic        uses;
        logic        ill;
    } exp_t;

    exp_t          mq[$];
    logic [SW-1:0] m_stall;

    imm_decode_stage #(.XLEN(32), .STALL_CNT_W(SW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_imm_src  (out_imm_src),
        .out_uses_imm (out_uses_imm),
        .out_illegal  (out_illegal),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected decode straight from the opcode table.
    function automatic exp_t model_decode(input logic [31:0] instr, input logic [31:0] pc);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        e.src   = 3'd0;
        e.uses  = 1'b1;
        e.ill   = 1'b0;
        case (instr[6:0])
            7'h03, 7'h13, 7'h67: e.src = 3'd0;
            7'h23:               e.src = 3'd1;
            7'h63:               e.src = 3'd2;
            7'h6F:               e.src = 3'd3;
            7'h37, 7'h17:        e.src = 3'd4;
            7'h33:               e.uses = 1'b0;
            default: begin
                e.uses = 1'b0;
                e.ill  = 1'b1;
            end
        endcase
        return e;
    endfunction

    task automatic compare_outputs();
        check("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
        check("in_ready", {31'd0, in_ready}, {31'd0, mq.size() < 2});
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        check("imm_src_known", {31'd0, $isunknown(out_imm_src)}, 32'd0);
        if (mq.size() > 0) begin
            check("out_instr", out_instr, mq[0].instr);
            check("out_pc", out_pc, mq[0].pc);
            check("out_imm_src", 32'(out_imm_src), 32'(mq[0].src));
            check("out_uses_imm", {31'd0, out_uses_imm}, {31'd0, mq[0].uses});
            check("out_illegal", {31'd0, out_illegal}, {31'd0, mq[0].ill});
        end
    endtask

    // One clock of stimulus; the model is a FIFO of capacity two.
    task automatic step(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                        input logic rdy, input logic fl, output logic acc);
        logic drn;
        in_valid  = v;
        in_instr  = instr;
        in_pc     = pc;
        out_ready = rdy;
        flush     = fl;
        acc = v && (mq.size() < 2);
        drn = (mq.size() > 0) && rdy;
        @(posedge clk);
        if (mq.size() > 0 && !rdy && m_stall != '1) m_stall++;
        if (fl) begin
            mq.delete();
        end else begin
            if (drn) void'(mq.pop_front());
            if (acc) mq.push_back(model_decode(instr, pc));
        end
        #1;
        compare_outputs();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_stall_cnt"}, 32'(stall_cnt), 32'd0);
        check({tag, "_out_instr"}, out_instr, 32'd0);
        check({tag, "_out_pc"}, out_pc, 32'd0);
        check({tag, "_imm_src"}, 32'(out_imm_src), 32'd0);
        check({tag, "_uses_imm"}, {31'd0, out_uses_imm}, 32'd0);
        check({tag, "_illegal"}, {31'd0, out_illegal}, 32'd0);
    endtask

    logic [31:0] stream[5] = '{32'h00500093, 32'h00112023, 32'hFE000EE3,
                               32'h008000EF, 32'h000012B7};
    logic [6:0]  ops[11] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h6F,
                             7'h37, 7'h17, 7'h33, 7'h7F, 7'h00};

    initial begin
        logic        acc, v, rdy, fl, pend;
        logic [31:0] ins, pc, r;

        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        flush = 1'b0; out_ready = 1'b0;
        m_stall = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;

        // Back-to-back stream of each immediate format.
        for (int k = 0; k < 5; k++) begin
            step(1'b1, stream[k], 32'h1000 + 32'(4 * k), 1'b1, 1'b0, acc);
            check("stream_src", 32'(out_imm_src), 32'(k));
        end
        step(1'b1, 32'h002081B3, 32'h2000, 1'b1, 1'b0, acc);
        check("add_uses_imm", {31'd0, out_uses_imm}, 32'd0);
        step(1'b1, 32'h0000007F, 32'h2004, 1'b1, 1'b0, acc);
        check("bad_illegal", {31'd0, out_illegal}, 32'd1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

        // Back-pressure: two accepted, third held until release.
        step(1'b1, 32'h00A00113, 32'h3000, 1'b0, 1'b0, acc);
        step(1'b1, 32'h00B00193, 32'h3004, 1'b0, 1'b0, acc);
        step(1'b1, 32'h00C00213, 32'h3008, 1'b0, 1'b0, acc);
        check("bp_third_blocked", {31'd0, acc}, 32'd0);
        step(1'b1, 32'h00C00213, 32'h3008, 1'b0, 1'b0, acc);
        pend = 1'b1;
        for (int i = 0; i < 8 && mq.size() + int'(pend) > 0; i++) begin
            step(pend, 32'h00C00213, 32'h3008, 1'b1, 1'b0, acc);
            if (acc) pend = 1'b0;
        end
        check("bp_drained", {31'd0, out_valid}, 32'd0);

        // Flush while FULL with a simultaneous input.
        step(1'b1, 32'h00D00293, 32'h4000, 1'b0, 1'b0, acc);
        step(1'b1, 32'h00E00313, 32'h4004, 1'b0, 1'b0, acc);
        step(1'b1, 32'h00F00393, 32'h4008, 1'b0, 1'b1, acc);
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (3) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

        // Saturation of the stall counter.
        step(1'b1, 32'h01000413, 32'h5000, 1'b0, 1'b0, acc);
        repeat (20) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);
        check("stall_saturated", 32'(stall_cnt), 32'd15);

        // Asynchronous reset with the stage FULL.
        step(1'b1, 32'h01100493, 32'h6000, 1'b0, 1'b0, acc);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        mq.delete();
        m_stall = '0;
        check_reset_values("async_rst");
        @(posedge clk);
        #1;
        check_reset_values("rst_held");
        rst_n = 1'b1;

        // Randomized traffic with occasional flush.
        pend = 1'b0;
        pc   = 32'h8000;
        ins  = '0;
        v    = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!pend) begin
                v  = ($urandom_range(0, 9) < 7);
                r  = $urandom();
                ins = {r[31:7], ops[$urandom_range(0, 10)]};
                if ($urandom_range(0, 3) == 0) ins[6:0] = r[6:0];
                pc = pc + 32'd4;
            end
            rdy = ($urandom_range(0, 9) < 6);
            fl  = ($urandom_range(0, 31) == 0);
            step(v, ins, pc, rdy, fl, acc);
            pend = v && !acc;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
